id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Scoreboard-based hazard controller for the in-order 16-bit pipeline. It tracks every in-flight register write between the ID stage and register-file writeback, and stalls ID whenever the decoded instruction reads or overwrites a register with an outstanding write. On branch redirect it kills the squashed writes, and it reports scoreboard/writeback mismatches. It sits beside `id_stage` and drives the IF/ID hold and ID/EX bubble controls.

## Interface
- `DEPTH`, 3: pipeline slots from ID issue to register-file write (EX, MEM, WB).
- `FLUSH_DEPTH`, 1: youngest slots squashed by `flush`. Legal range is 0..DEPTH-1.
- `clk` in 1: pipeline clock.
- `rst` in 1: reset. Synchronous, active-high.
- `id_valid` in 1: the ID stage holds a valid instruction.
- `id_rd`, `id_rs1`, `id_rs2` in 4 each: register fields decoded in ID.
- `id_writes_rd`, `id_uses_rs1`, `id_uses_rs2` in 1 each: per-opcode usage flags, taken from the shared package decode.
- `flush` in 1: branch redirect. Kills the ID instruction and the youngest FLUSH_DEPTH slots.
- `wb_reg_write` in 1, `wb_rd` in 4: the writeback port as presented to the regfile.
- `stall` out 1: hold IF/ID and insert a bubble into ID/EX.
- `issue` out 1: the ID instruction advances this cycle.
- `pending` out 16: bit r is set while any valid slot targets register r.
- `stall_cnt` out 16: saturating count of stall cycles.
- `sb_err` out 1: sticky writeback-mismatch flag.

## Operation
- State is a shift register `slot[0..DEPTH-1]`, each entry `{v, rd}`. `slot[0]` is EX; `slot[DEPTH-1]` is the write committed at the current clock edge.
- The pipeline shifts every cycle; downstream stages never stall. `slot[k+1] <= slot[k]`.
- `slot[0]` load value:
  - `{1, id_rd}` when `issue & id_writes_rd`.
  - Otherwise `{0, x}`, i.e. a bubble.
- `hit(r)` = OR over all k of (`slot[k].v & slot[k].rd == r`).
- Stall condition: `stall` = `id_valid & ~flush & ((id_uses_rs1 & hit(rs1)) | (id_uses_rs2 & hit(rs2)) | (id_writes_rd & hit(rd)))`.
  - The rd term prevents WAW reordering.
  - The WB slot is included because the regfile writes at the edge, so same-cycle reads return the old value.
- `issue` = `id_valid & ~flush & ~stall`.
- Flush:
  - Slots 0..FLUSH_DEPTH-1 are invalidated before the shift.
  - The ID instruction is not loaded.
  - Flush overrides stall: `stall`=0 during flush.
- Writeback check: in every cycle, `wb_reg_write` must equal `slot[DEPTH-1].v`, and when valid `wb_rd` must equal `slot[DEPTH-1].rd`. Any mismatch sets `sb_err` until reset.
- `stall_cnt` increments on each cycle with `stall`=1 and saturates at 16'hFFFF.
- `pending` is the OR-decode of all valid slots.

## Timing
- `stall`, `issue` and `pending` are combinational from the current state plus ID inputs, with zero-cycle latency.
- A stalled instruction re-evaluates every cycle. A RAW hazard on the immediately preceding writer therefore costs exactly DEPTH stall cycles with default parameters.
- Reset, applied on the clock edge with `rst`=1:
  - All slots invalid, `pending`=0, `stall`=0 once ID inputs are idle.
  - `stall_cnt`=0, `sb_err`=0.
  - Reset asserted mid-stall drops all outstanding hazards at that edge.
- Simultaneous issue to rd=r and commit of r from the WB slot: the new slot[0] entry keeps `pending[r]`=1 in the next cycle. No hazard is lost.
- `flush` together with an unrelated commit: the commit proceeds, because slot DEPTH-1 is never flushed while FLUSH_DEPTH < DEPTH.

## Configuration
- `HAZARD_R0_ZERO_EN`
  - Defined: register 0 is architecturally zero. `hit(0)` is forced to 0, writes with rd=0 load a bubble, and `pending[0]` is always 0.
  - Undefined: r0 is tracked like any other register.

## Structure
- Shared package (`def_opcode.v` companion, `def_pipe.v`) holds:
  - `PIPE_DEPTH` and `FLUSH_DEPTH` defaults.
  - The `REG_W`=4 / `DATA_W`=16 constants.
  - The per-opcode `writes_rd` / `uses_rs1` / `uses_rs2` lookup, so ID and this block agree.
- One sub-module, `hazard_slot_match`: compares a 4-bit register index against all slots and returns `hit`. It is instantiated three times (rs1, rs2, rd).

## Test plan
- ADD r3 issued in cycle 0, then dependent `SUB r4,r3,r1` -> `stall`=1 for cycles 1–3, `issue`=1 in cycle 4, `stall_cnt`=3.
- Independent instructions back to back (r1..r5 disjoint) -> `stall` never asserted, and `pending` walks each rd for exactly 3 cycles.
- r3 writer in EX and a dependent instruction stalled in ID, then `flush`=1 -> `stall`=0, slot 0 cleared, `pending[3]`=0 next cycle, no `issue`.
- `wb_reg_write`=1 with `wb_rd`=5 while the WB slot holds r6 -> `sb_err`=1 next cycle and held after the bus returns to normal.
- Write to r0 then read r0: `HAZARD_R0_ZERO_EN` defined -> no stall; undefined -> 3 stall cycles.
- `rst` asserted in the second cycle of a RAW stall -> next cycle `pending`=0, `stall`=0, `stall_cnt`=0, and the dependent instruction issues.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// ------------------------------------------------------------------
// id_hazard_ctrl_pkg : pipeline constants and per-opcode register-usage decode
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package id_hazard_ctrl_pkg;

  localparam int REG_W            = 4;
  localparam int DATA_W           = 16;
  localparam int NREG             = 1 << REG_W;
  localparam int PIPE_DEPTH       = 3;
  localparam int PIPE_FLUSH_DEPTH = 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LI   = 4'd6,
    OP_LW   = 4'd7,
    OP_SW   = 4'd8,
    OP_BEQ  = 4'd9,
    OP_JAL  = 4'd10
  } opcode_e;

  typedef struct packed {
    logic writes_rd;
    logic uses_rs1;
    logic uses_rs2;
  } reg_use_t;

  // Single source of truth for ID decode and the hazard scoreboard.
  function automatic reg_use_t decode_reg_use(input opcode_e op);
    reg_use_t u;
    u = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: u = '{writes_rd: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b1};
      OP_ADDI, OP_LW:                u = '{writes_rd: 1'b1, uses_rs1: 1'b1, uses_rs2: 1'b0};
      OP_LI, OP_JAL:                 u = '{writes_rd: 1'b1, uses_rs1: 1'b0, uses_rs2: 1'b0};
      OP_SW, OP_BEQ:                 u = '{writes_rd: 1'b0, uses_rs1: 1'b1, uses_rs2: 1'b1};
      default:                       u = '0;
    endcase
    return u;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_hazard_ctrl_slot_match.sv
// ------------------------------------------------------------------
// hazard_slot_match : 1 when any valid scoreboard slot targets i_reg.  Opt: HAZARD_R0_ZERO_EN
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hazard_slot_match
  import id_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic [DEPTH-1:0]            i_slot_v,
  input  logic [DEPTH-1:0][REG_W-1:0] i_slot_rd,
  input  logic [REG_W-1:0]            i_reg,
  output logic                        o_hit
);

  logic [DEPTH-1:0] w_match;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign w_match[k] = i_slot_v[k] && (i_slot_rd[k] == i_reg);
  end

`ifdef HAZARD_R0_ZERO_EN
  assign o_hit = (|w_match) && (i_reg != '0);
`else
  assign o_hit = |w_match;
`endif

endmodule

`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
// ------------------------------------------------------------------
// id_hazard_ctrl : scoreboard hazard stall, flush kill and writeback check.  Opt: HAZARD_R0_ZERO_EN
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH       = PIPE_DEPTH,
  parameter int FLUSH_DEPTH = PIPE_FLUSH_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_valid,
  input  logic [REG_W-1:0]  i_id_rd,
  input  logic [REG_W-1:0]  i_id_rs1,
  input  logic [REG_W-1:0]  i_id_rs2,
  input  logic              i_id_writes_rd,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic              i_flush,
  input  logic              i_wb_reg_write,
  input  logic [REG_W-1:0]  i_wb_rd,
  output logic              o_stall,
  output logic              o_issue,
  output logic [NREG-1:0]   o_pending,
  output logic [DATA_W-1:0] o_stall_cnt,
  output logic              o_sb_err
);

  logic [DEPTH-1:0]            r_slot_v;
  logic [DEPTH-1:0][REG_W-1:0] r_slot_rd;
  logic [DATA_W-1:0]           r_stall_cnt;
  logic                        r_sb_err;

  logic            w_hit_rs1, w_hit_rs2, w_hit_rd;
  logic            w_stall, w_issue, w_load_v, w_wb_mismatch;
  logic [NREG-1:0] w_pending;

  hazard_slot_match #(.DEPTH(DEPTH)) u_hit_rs1 (
    .i_slot_v(r_slot_v), .i_slot_rd(r_slot_rd), .i_reg(i_id_rs1), .o_hit(w_hit_rs1)
  );
  hazard_slot_match #(.DEPTH(DEPTH)) u_hit_rs2 (
    .i_slot_v(r_slot_v), .i_slot_rd(r_slot_rd), .i_reg(i_id_rs2), .o_hit(w_hit_rs2)
  );
  hazard_slot_match #(.DEPTH(DEPTH)) u_hit_rd (
    .i_slot_v(r_slot_v), .i_slot_rd(r_slot_rd), .i_reg(i_id_rd), .o_hit(w_hit_rd)
  );

  assign w_stall = i_id_valid && !i_flush &&
                   ((i_id_uses_rs1 && w_hit_rs1) ||
                    (i_id_uses_rs2 && w_hit_rs2) ||
                    (i_id_writes_rd && w_hit_rd));
  assign w_issue = i_id_valid && !i_flush && !w_stall;

`ifdef HAZARD_R0_ZERO_EN
  assign w_load_v = w_issue && i_id_writes_rd && (i_id_rd != '0);
`else
  assign w_load_v = w_issue && i_id_writes_rd;
`endif

  // The oldest slot is exactly the write the regfile commits this edge.
  assign w_wb_mismatch = (i_wb_reg_write != r_slot_v[DEPTH-1]) ||
                         (r_slot_v[DEPTH-1] && (i_wb_rd != r_slot_rd[DEPTH-1]));

  always_comb begin
    w_pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_slot_v[k]) w_pending[r_slot_rd[k]] = 1'b1;
    end
`ifdef HAZARD_R0_ZERO_EN
    w_pending[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_v    <= '0;
      r_slot_rd   <= '0;
      r_stall_cnt <= '0;
      r_sb_err    <= 1'b0;
    end else begin
      r_slot_v[0]  <= w_load_v;
      r_slot_rd[0] <= i_id_rd;
      // Flush squashes the youngest slots as they move down the pipe.
      for (int k = 1; k < DEPTH; k++) begin
        r_slot_v[k]  <= r_slot_v[k-1] && !(i_flush && ((k - 1) < FLUSH_DEPTH));
        r_slot_rd[k] <= r_slot_rd[k-1];
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + DATA_W'(1);
      if (w_wb_mismatch) r_sb_err <= 1'b1;
    end
  end

  assign o_stall     = w_stall;
  assign o_issue     = w_issue;
  assign o_pending   = w_pending;
  assign o_stall_cnt = r_stall_cnt;
  assign o_sb_err    = r_sb_err;

endmodule

`default_nettype wire
